dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Data-memory controller between the EX/MEM pipeline register and a word-wide synchronous single-port RAM.
- Executes RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW from byte addresses.
- Sub-word stores use read-modify-write because the RAM has no byte enables.
- Raises `stall` to freeze upstream stages while a multi-cycle access is in flight.

Parameters:
- DM_ADDRESS, 9, byte-address width; RAM word index is addr[DM_ADDRESS-1:2].
- DATA_W, 32, data width; only 32 supported.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM; wins if both asserted.
- func3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr  in  DM_ADDRESS  byte address.
- wr_data  in  DATA_W  store data, right-justified.
- rd_data  out  DATA_W  extended load result.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- stall  out  1  holds upstream pipeline and this request stable.
- misalign  out  1  one-cycle pulse on misaligned or illegal access.
- ram_addr  out  DM_ADDRESS-2  RAM word index.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write word.
- ram_rdata  in  DATA_W  RAM read word; valid the cycle after ram_addr is presented.

Behaviour:
- States: IDLE, LOAD, RMW. ram_addr = addr[DM_ADDRESS-1:2] in all states. Request inputs are held stable by upstream while stall=1.
- Reset values: state=IDLE, rd_data=0, rd_valid=0, misalign=0, stall=0. ram_we is forced 0 during any reset cycle.
- Reset mid-operation aborts the access; no RAM write is issued.
- IDLE, no request: stall=0, ram_we=0.
- IDLE, request checks:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0 is misaligned.
  - func3 in {011, 110, 111} is illegal.
  - Either condition: misalign=1 for one cycle, stall=0, no RAM write, rd_data unchanged, rd_valid=0.
- IDLE, load: stall=1, next state LOAD.
- LOAD: stall=0, rd_valid=1, next state IDLE. rd_data is registered at the end of the cycle from ram_rdata:
  - Lane selected by addr[1:0] (byte) or addr[1] (half).
  - Sign-extended for B/H; zero-extended for BU/HU.
  - rd_data holds until the next completed load.
- IDLE, SW: single cycle. ram_we=1, ram_wdata=wr_data, stall=0, stay IDLE.
- IDLE, SB/SH: stall=1, next state RMW.
- RMW: ram_we=1, stall=0, next state IDLE. ram_wdata = ram_rdata with the addressed byte/half lane replaced by wr_data[7:0] or wr_data[15:0].
- Latency: LW/LB/LH/LBU/LHU and SB/SH take 2 cycles (1 stall cycle). SW and faults take 1 cycle.
- Back-to-back requests are accepted in the cycle after LOAD/RMW.
- Address wrap: none. Word index is truncated to DM_ADDRESS-2 bits.

Optional Feature:
- Macro: DMEM_PERF_EN.
- Defined: adds outputs load_cnt, store_cnt, stall_cnt (32 bits each).
  - load_cnt and store_cnt increment on each completed access (LOAD exit, RMW exit, SW accept).
  - stall_cnt increments on every cycle with stall=1.
  - Counters clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package Dmem_Ctrl_PKG:
  - dmem_state_t enum (IDLE, LOAD, RMW).
  - func3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module load_extend: combinational lane select plus sign/zero extension, shared by LOAD path and bench reference model.

Test Plan:
- SW addr=0x010 wr_data=0xDEADBEEF, then LW addr=0x010 -> ram_we pulse at word 4; stall=1 one cycle; rd_data=0xDEADBEEF with rd_valid.
- Word 4 = 0xDEADBEEF:
  - LB 0x013 -> rd_data=0xFFFFFFDE.
  - LBU 0x013 -> 0x000000DE.
  - LH 0x012 -> 0xFFFFDEAD.
  - LHU 0x010 -> 0x0000BEEF.
- SB addr=0x011 wr_data=0x55 on word 0x11223344 -> RMW writes 0x11225544; stall high exactly one cycle.
- LW addr=0x006; SH addr=0x003; func3=011 -> misalign pulse each time; no ram_we; stall=0.
- Assert reset in the LOAD and RMW cycles -> state IDLE, ram_we=0, RAM contents unchanged, rd_data=0.
- Issue 10 loads and 10 SB stores back to back -> no lost requests. With DMEM_PERF_EN: load_cnt=10, store_cnt=10, stall_cnt=20.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and func3 encodings for the data-memory controller.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RMW
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the request must be rejected: unknown func3 or a misaligned half/word.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lane);
        logic fault;
        case (f3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = lane[0];
            F3_W:        fault = (lane != 2'b00);
            default:     fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/dmem_ctrl_load_extend.sv
// Load lane select with sign/zero extension of a RAM word.
module load_extend
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [2:0]        func3,
    input  logic [1:0]        lane,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (func3)
            F3_B:    result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_BU:   result = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_H:    result = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_HU:   result = {{(DATA_W-16){1'b0}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// RISC-V data-memory controller with read-modify-write sub-word stores.
// Define DMEM_PERF_EN to add load/store/stall performance counters.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [2:0]              func3,
    input  logic [DM_ADDRESS-1:0]   addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    stall,
    output logic                    misalign,
    output logic [DM_ADDRESS-3:0]   ram_addr,
    output logic                    ram_we,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata
`ifdef DMEM_PERF_EN
    ,
    output logic [31:0]             load_cnt,
    output logic [31:0]             store_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    dmem_state_t       state, state_next;
    logic              fault;
    logic              load_done;
    logic              store_done;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] merged;

    assign ram_addr = addr[DM_ADDRESS-1:2];
    assign fault    = access_fault(func3, addr[1:0]);

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .word   (ram_rdata),
        .func3  (func3),
        .lane   (addr[1:0]),
        .result (load_word)
    );

    // Sub-word store: replace only the addressed lane of the word read in IDLE.
    always_comb begin
        merged = ram_rdata;
        if (func3[0])
            merged[{addr[1], 4'b0000} +: 16] = wr_data[15:0];
        else
            merged[{addr[1:0], 3'b000} +: 8] = wr_data[7:0];
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = wr_data;
        rd_valid   = 1'b0;
        misalign   = 1'b0;
        load_done  = 1'b0;
        store_done = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    if (fault) begin
                        misalign = 1'b1;
                    end else if (mem_write) begin
                        if (func3 == F3_W) begin
                            ram_we     = 1'b1;
                            store_done = 1'b1;
                        end else begin
                            stall      = 1'b1;
                            state_next = RMW;
                        end
                    end else begin
                        stall      = 1'b1;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                rd_valid   = 1'b1;
                load_done  = 1'b1;
                state_next = IDLE;
            end
            RMW: begin
                ram_we     = 1'b1;
                ram_wdata  = merged;
                store_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A reset cycle aborts whatever is in flight, including a pending RAM write.
        if (reset) begin
            state_next = IDLE;
            stall      = 1'b0;
            ram_we     = 1'b0;
            rd_valid   = 1'b0;
            misalign   = 1'b0;
            load_done  = 1'b0;
            store_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rd_data <= '0;
        end else begin
            state <= state_next;
            if (load_done)
                rd_data <= load_word;
        end
    end

`ifdef DMEM_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (load_done)
                load_cnt <= load_cnt + 32'd1;
            if (store_done)
                store_cnt <= store_cnt + 32'd1;
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed steps plus random traffic vs a word-array model.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        stall;
    logic        misalign;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef DMEM_PERF_EN
    logic [31:0] load_cnt;
    logic [31:0] store_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .func3     (func3),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .stall     (stall),
        .misalign  (misalign),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef DMEM_PERF_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Synchronous single-port RAM, read-before-write.
    logic [31:0] ram [0:127];
    always @(posedge clk) begin
        if (ram_we)
            ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    logic [31:0] ref_mem [0:127];
    logic [31:0] ref_rd;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_fault(input logic [2:0] f3, input logic [8:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (f3 == 1 || f3 == 5) return a[0];
        if (f3 == 2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [8:0] a);
        int unsigned bsh = 8 * int'(a[1:0]);
        int unsigned hsh = 16 * int'(a[1]);
        logic [31:0] b = (w >> bsh) & 32'hFF;
        logic [31:0] h = (w >> hsh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b ^ 32'h80) - 32'h80;
            3'd4:    return b;
            3'd1:    return (h ^ 32'h8000) - 32'h8000;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        int unsigned bsh = 8 * int'(a[1:0]);
        int unsigned hsh = 16 * int'(a[1]);
        if (f3 == 2) return d;
        if (f3 == 1) return (w & ~(32'hFFFF << hsh)) | ((d & 32'hFFFF) << hsh);
        return (w & ~(32'hFF << bsh)) | ((d & 32'hFF) << bsh);
    endfunction

    // One request from the cycle it is presented until it retires; leaves inputs driven.
    task automatic access(input bit wr, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d, input string tag);
        bit flt;
        bit multi;
        logic [6:0] w;
        flt   = ref_fault(f3, a);
        multi = !flt && !(wr && f3 == 3'd2);
        w     = a[8:2];
        mem_read = !wr; mem_write = wr; func3 = f3; addr = a; wr_data = d;
        @(negedge clk);
        chk({tag, " stall"}, 32'(stall), 32'(multi));
        chk({tag, " misalign"}, 32'(misalign), 32'(flt));
        chk({tag, " ram_addr"}, 32'(ram_addr), 32'(w));
        chk({tag, " rd_valid0"}, 32'(rd_valid), 32'd0);
        if (wr && !flt && f3 == 3'd2) begin
            chk({tag, " sw_we"}, 32'(ram_we), 32'd1);
            chk({tag, " sw_wdata"}, ram_wdata, d);
        end else begin
            chk({tag, " we0"}, 32'(ram_we), 32'd0);
        end
        if (multi) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, " stall2"}, 32'(stall), 32'd0);
            chk({tag, " misalign2"}, 32'(misalign), 32'd0);
            if (wr) begin
                chk({tag, " rmw_we"}, 32'(ram_we), 32'd1);
                chk({tag, " rmw_wdata"}, ram_wdata, ref_store(ref_mem[w], f3, a, d));
                chk({tag, " rmw_rd_valid"}, 32'(rd_valid), 32'd0);
            end else begin
                chk({tag, " load_we"}, 32'(ram_we), 32'd0);
                chk({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
            end
        end
        @(posedge clk); #1;
        if (!flt) begin
            if (wr) ref_mem[w] = ref_store(ref_mem[w], f3, a, d);
            else    ref_rd     = ref_load(ref_mem[w], f3, a);
        end
        chk({tag, " rd_data"}, rd_data, ref_rd);
        chk({tag, " ram_word"}, ram[w], ref_mem[w]);
    endtask

    task automatic idle_cycle();
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("idle stall", 32'(stall), 32'd0);
        chk("idle we", 32'(ram_we), 32'd0);
        chk("idle misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
    endtask

    // Present a multi-cycle request, then reset during its second cycle.
    task automatic reset_during(input bit wr, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d, input string tag);
        logic [6:0] w;
        w = a[8:2];
        mem_read = !wr; mem_write = wr; func3 = f3; addr = a; wr_data = d;
        @(negedge clk);
        chk({tag, " stall"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk({tag, " rst_stall"}, 32'(stall), 32'd0);
        chk({tag, " rst_we"}, 32'(ram_we), 32'd0);
        chk({tag, " rst_rd_valid"}, 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ref_rd = '0;
        chk({tag, " rst_rd_data"}, rd_data, 32'd0);
        chk({tag, " rst_ram"}, ram[w], ref_mem[w]);
        idle_cycle();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] d;
        bit          wr;
`ifdef DMEM_PERF_EN
        logic [31:0] lc0, sc0, tc0;
`endif
        for (int i = 0; i < 128; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        ref_rd = '0;
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'd2; addr = '0; wr_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset we", 32'(ram_we), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        chk("reset misalign", 32'(misalign), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_read = 1'b0;
        chk("reset rd_data", rd_data, 32'd0);
        idle_cycle();

        access(1, 3'd2, 9'h010, 32'hDEADBEEF, "sw");
        access(0, 3'd2, 9'h010, 32'h0, "lw");
        chk("lw value", rd_data, 32'hDEADBEEF);
        access(0, 3'd0, 9'h013, 32'h0, "lb");
        chk("lb value", rd_data, 32'hFFFFFFDE);
        access(0, 3'd4, 9'h013, 32'h0, "lbu");
        chk("lbu value", rd_data, 32'h000000DE);
        access(0, 3'd1, 9'h012, 32'h0, "lh");
        chk("lh value", rd_data, 32'hFFFFDEAD);
        access(0, 3'd5, 9'h010, 32'h0, "lhu");
        chk("lhu value", rd_data, 32'h0000BEEF);

        access(1, 3'd2, 9'h010, 32'h11223344, "sw2");
        access(1, 3'd0, 9'h011, 32'h00000055, "sb");
        chk("sb word", ram[4], 32'h11225544);
        idle_cycle();

        access(0, 3'd2, 9'h006, 32'h0, "lw_mis");
        access(1, 3'd1, 9'h003, 32'hFFFF, "sh_mis");
        access(0, 3'd3, 9'h008, 32'h0, "f3_011");
        idle_cycle();

        reset_during(0, 3'd0, 9'h011, 32'h0, "rst_load");
        reset_during(1, 3'd0, 9'h011, 32'hAA, "rst_rmw");

`ifdef DMEM_PERF_EN
        lc0 = load_cnt; sc0 = store_cnt; tc0 = stall_cnt;
`endif
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            a = 9'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            if (f3 == 3'd2) a[1:0] = 2'b00;
            access(0, f3, a, 32'h0, "b2b_load");
            access(1, 3'd0, 9'($urandom), $urandom, "b2b_sb");
        end
        idle_cycle();
`ifdef DMEM_PERF_EN
        chk("perf load_cnt", load_cnt - lc0, 32'd10);
        chk("perf store_cnt", store_cnt - sc0, 32'd10);
        chk("perf stall_cnt", stall_cnt - tc0, 32'd20);
`endif

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom);
            if (wr) begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd3;
                    4: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            a = 9'($urandom);
            d = $urandom;
            access(wr, f3, a, d, "rand");
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
